// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX scheduling slice.
//   tx_state_e    : scheduler FSM state encoding
//   C_TAG_BASE    : upper bits of the channel-tag byte
//   C_DEFAULT_DIV : TX clock divider after reset (50 MHz / 115200)
//   WD_W          : width of the per-byte watchdog counter
//   IDX_W         : width of requester indices (up to 8 requesters)
//   rr_next       : round-robin pointer advance with wrap
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_TAG  = 3'd1,
        ST_WAIT_TAG  = 3'd2,
        ST_SEND_DATA = 3'd3,
        ST_WAIT_DATA = 3'd4
    } tx_state_e;

    localparam logic [7:0] C_TAG_BASE    = 8'hA0;
    localparam logic [9:0] C_DEFAULT_DIV = 10'd434;
    localparam int         WD_W          = 16;
    localparam int         IDX_W         = 3;

    // Index following idx, wrapping to 0 after the last requester.
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx,
                                                 input logic [IDX_W-1:0] last);
        if (idx >= last) begin
            rr_next = '0;
        end else begin
            rr_next = idx + IDX_W'(1);
        end
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or above
// the pointer, wrapping around. Shared between the TX scheduler and RX routing.
//   iReq    : request vector
//   iPtr    : search start index (must be < C_NUM_REQ)
//   oWinner : one-hot winner, 0 when no request
//   oIdx    : index of the winner
//   oValid  : at least one request present
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter int C_NUM_REQ = 4
) (
    input  logic [C_NUM_REQ-1:0] iReq,
    input  logic [IDX_W-1:0]     iPtr,
    output logic [C_NUM_REQ-1:0] oWinner,
    output logic [IDX_W-1:0]     oIdx,
    output logic                 oValid
);

    localparam int               LW    = (C_NUM_REQ > 2) ? $clog2(C_NUM_REQ) : 1;
    localparam logic [IDX_W:0]   NUM_L = (IDX_W+1)'(C_NUM_REQ);

    logic [IDX_W:0] cand_s;

    // Walk the requesters starting at the pointer; the first hit wins.
    always_comb begin
        oWinner = '0;
        oIdx    = '0;
        oValid  = 1'b0;
        cand_s  = '0;
        for (int i = 0; i < C_NUM_REQ; i++) begin
            cand_s = {1'b0, iPtr} + (IDX_W+1)'(i);
            if (cand_s >= NUM_L) begin
                cand_s = cand_s - NUM_L;
            end else begin
                cand_s = cand_s;
            end
            if (!oValid && iReq[cand_s[LW-1:0]]) begin
                oValid                   = 1'b1;
                oWinner[cand_s[LW-1:0]]  = 1'b1;
                oIdx                     = cand_s[IDX_W-1:0];
            end else begin
                oValid = oValid;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among C_NUM_REQ byte requesters (round robin),
// optionally prefixing each byte with a channel tag, latching TX config only
// at grant time and aborting any byte that exceeds the watchdog budget.
//   iReq_Val/iReq_Data/oReq_Ack : requester side (data held until ack)
//   iTag_en                     : send tag byte before each data byte
//   iCfg_*  -> oTx_*            : TX config, sampled at grant
//   oTx_Val/oTx_Data            : one-cycle send strobe and byte
//   iTx_Rdy/iTx_done            : transmitter idle / byte finished
//   oGrant/oBusy/oTimeout       : status
module uart_tx_scheduler #(
    parameter int          C_NUM_REQ     = 4,
    parameter logic [9:0]  C_DEFAULT_DIV = uart_pkg::C_DEFAULT_DIV,
    parameter logic [15:0] C_TIMEOUT     = 16'd8000,
    parameter logic [7:0]  C_TAG_BASE    = uart_pkg::C_TAG_BASE
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic [C_NUM_REQ-1:0]   iReq_Val,
    input  logic [8*C_NUM_REQ-1:0] iReq_Data,
    output logic [C_NUM_REQ-1:0]   oReq_Ack,
    input  logic                   iTag_en,
    input  logic [9:0]             iCfg_Clk_Div,
    input  logic                   iCfg_Check_odd,
    input  logic                   iCfg_Check_even,
    output logic [9:0]             oTx_Clk_Div,
    output logic                   oTx_Check_odd,
    output logic                   oTx_Check_even,
    output logic                   oTx_Val,
    output logic [7:0]             oTx_Data,
    input  logic                   iTx_Rdy,
    input  logic                   iTx_done,
    output logic [C_NUM_REQ-1:0]   oGrant,
    output logic                   oBusy,
    output logic                   oTimeout
);

    import uart_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_NUM_REQ - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = C_TIMEOUT - WD_W'(1);

    tx_state_e            state_r, state_s;
    logic [IDX_W-1:0]     ptr_r, ptr_s, win_idx_r, win_idx_s;
    logic [C_NUM_REQ-1:0] grant_r, grant_s, ack_r, ack_s;
    logic [7:0]           byte_r, byte_s, tx_data_r, tx_data_s, req_byte_s;
    logic                 tx_val_r, tx_val_s, timeout_r, timeout_s, busy_r;
    logic [9:0]           div_r, div_s;
    logic                 odd_r, odd_s, even_r, even_s;
    logic [WD_W-1:0]      wd_r, wd_s;
    logic                 done_prev_r, done_rise_s, wd_expired_s;
    logic [C_NUM_REQ-1:0] arb_win_s;
    logic [IDX_W-1:0]     arb_idx_s;
    logic                 arb_any_s;

    uart_rr_arbiter #(.C_NUM_REQ(C_NUM_REQ)) u_arb (
        .iReq    (iReq_Val),
        .iPtr    (ptr_r),
        .oWinner (arb_win_s),
        .oIdx    (arb_idx_s),
        .oValid  (arb_any_s)
    );

    assign done_rise_s  = iTx_done & ~done_prev_r;
    assign wd_expired_s = (wd_r == WD_LAST);

    // One-hot mux of the winning requester's byte.
    always_comb begin
        req_byte_s = 8'd0;
        for (int k = 0; k < C_NUM_REQ; k++) begin
            req_byte_s = req_byte_s | ({8{arb_win_s[k]}} & iReq_Data[8*k +: 8]);
        end
    end

    // Next-state and next-output logic of the scheduler FSM.
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        win_idx_s = win_idx_r;
        grant_s   = grant_r;
        ack_s     = '0;
        byte_s    = byte_r;
        tx_data_s = tx_data_r;
        tx_val_s  = 1'b0;
        timeout_s = 1'b0;
        div_s     = div_r;
        odd_s     = odd_r;
        even_s    = even_r;
        wd_s      = wd_r;
        case (state_r)
            ST_IDLE: begin
                if (arb_any_s) begin
                    state_s   = iTag_en ? ST_SEND_TAG : ST_SEND_DATA;
                    grant_s   = arb_win_s;
                    ack_s     = arb_win_s;
                    win_idx_s = arb_idx_s;
                    byte_s    = req_byte_s;
                    div_s     = iCfg_Clk_Div;
                    odd_s     = iCfg_Check_odd;
                    even_s    = iCfg_Check_even;
                    wd_s      = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND_TAG, ST_SEND_DATA: begin
                // Expiry beats a late ready so an aborted byte is never started.
                if (wd_expired_s) begin
                    state_s   = ST_IDLE;
                    grant_s   = '0;
                    ptr_s     = rr_next(win_idx_r, LAST_IDX);
                    timeout_s = 1'b1;
                end else if (iTx_Rdy) begin
                    tx_val_s  = 1'b1;
                    tx_data_s = (state_r == ST_SEND_TAG)
                                ? (C_TAG_BASE | {5'd0, win_idx_r}) : byte_r;
                    state_s   = (state_r == ST_SEND_TAG) ? ST_WAIT_TAG : ST_WAIT_DATA;
                    wd_s      = wd_r + WD_W'(1);
                end else begin
                    wd_s = wd_r + WD_W'(1);
                end
            end
            ST_WAIT_TAG: begin
                if (done_rise_s) begin
                    state_s = ST_SEND_DATA;
                    wd_s    = '0;
                end else if (wd_expired_s) begin
                    state_s   = ST_IDLE;
                    grant_s   = '0;
                    ptr_s     = rr_next(win_idx_r, LAST_IDX);
                    timeout_s = 1'b1;
                end else begin
                    wd_s = wd_r + WD_W'(1);
                end
            end
            ST_WAIT_DATA: begin
                // A done edge on the expiry cycle still completes the byte.
                if (done_rise_s) begin
                    state_s = ST_IDLE;
                    grant_s = '0;
                    ptr_s   = rr_next(win_idx_r, LAST_IDX);
                end else if (wd_expired_s) begin
                    state_s   = ST_IDLE;
                    grant_s   = '0;
                    ptr_s     = rr_next(win_idx_r, LAST_IDX);
                    timeout_s = 1'b1;
                end else begin
                    wd_s = wd_r + WD_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = '0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r     <= ST_IDLE;
            ptr_r       <= '0;
            win_idx_r   <= '0;
            grant_r     <= '0;
            ack_r       <= '0;
            byte_r      <= 8'd0;
            tx_data_r   <= 8'd0;
            tx_val_r    <= 1'b0;
            timeout_r   <= 1'b0;
            busy_r      <= 1'b0;
            div_r       <= C_DEFAULT_DIV;
            odd_r       <= 1'b0;
            even_r      <= 1'b0;
            wd_r        <= '0;
            done_prev_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            win_idx_r   <= win_idx_s;
            grant_r     <= grant_s;
            ack_r       <= ack_s;
            byte_r      <= byte_s;
            tx_data_r   <= tx_data_s;
            tx_val_r    <= tx_val_s;
            timeout_r   <= timeout_s;
            busy_r      <= (state_s != ST_IDLE);
            div_r       <= div_s;
            odd_r       <= odd_s;
            even_r      <= even_s;
            wd_r        <= wd_s;
            done_prev_r <= iTx_done;
        end
    end

    assign oReq_Ack       = ack_r;
    assign oGrant         = grant_r;
    assign oTx_Val        = tx_val_r;
    assign oTx_Data       = tx_data_r;
    assign oTimeout       = timeout_r;
    assign oBusy          = busy_r;
    assign oTx_Clk_Div    = div_r;
    assign oTx_Check_odd  = odd_r;
    assign oTx_Check_even = even_r;

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UART transmitter (Uart_Interface TX side) among C_NUM_REQ byte requesters using round-robin arbitration.
- Optionally prefixes each byte with a channel-tag byte so the far end can demultiplex the stream.
- Owns TX configuration (clock divider, parity): latches it only between transactions and drives it to the transmitter.
- Runs a per-byte watchdog so a stalled transmitter cannot lock the scheduler.

Parameters:
- C_NUM_REQ, 4: number of requesters, 2..8.
- C_DEFAULT_DIV, 434: oTx_Clk_Div value after reset (50 MHz / 115200).
- C_TIMEOUT, 16'd8000: maximum cycles per byte, measured from SEND entry to done.
- C_TAG_BASE, 8'hA0: tag byte is C_TAG_BASE | channel index (low 3 bits).

Ports:
- Clk  in  1  system clock.
- Rst_n  in  1  asynchronous active-low reset.
- iReq_Val  in  C_NUM_REQ  per-requester valid; held with its data until acknowledged.
- iReq_Data  in  8*C_NUM_REQ  byte for requester k at [8k+7:8k].
- oReq_Ack  out  C_NUM_REQ  one-cycle acknowledge; the byte was captured.
- iTag_en  in  1  1 = send tag byte before each data byte.
- iCfg_Clk_Div  in  10  requested TX divider.
- iCfg_Check_odd  in  1  requested odd parity.
- iCfg_Check_even  in  1  requested even parity.
- oTx_Clk_Div  out  10  divider to transmitter.
- oTx_Check_odd  out  1  parity select to transmitter.
- oTx_Check_even  out  1  parity select to transmitter.
- oTx_Val  out  1  one-cycle send strobe to transmitter.
- oTx_Data  out  8  byte to transmitter; valid with oTx_Val.
- iTx_Rdy  in  1  transmitter idle.
- iTx_done  in  1  transmitter finished a byte (level or pulse).
- oGrant  out  C_NUM_REQ  one-hot owner of the current transaction; 0 when idle.
- oBusy  out  1  state != IDLE.
- oTimeout  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Reset values:
  - all outputs 0, except oTx_Clk_Div = C_DEFAULT_DIV.
  - RR pointer = 0; state = IDLE.
  - Reset acts immediately (asynchronous), including mid-byte; oTx_Val drops at once.
- FSM states: IDLE, SEND_TAG, WAIT_TAG, SEND_DATA, WAIT_DATA.
- IDLE, when any iReq_Val is high, on the next edge:
  - winner = first set bit searching from the pointer upward, with wrap.
  - oGrant = winner; the winner's byte is latched and its oReq_Ack pulses for 1 cycle.
  - iCfg_* are latched into oTx_*; iTag_en is latched.
  - next state = SEND_TAG if tag enabled, else SEND_DATA.
- Config is only sampled here; changes to iCfg_* at any other time have no effect until the next grant.
- SEND_x: when iTx_Rdy = 1, pulse oTx_Val for exactly 1 cycle and go to WAIT_x.
  - oTx_Data = tag byte (SEND_TAG) or latched byte (SEND_DATA).
  - oTx_Data holds its value until the next send.
- WAIT_x: a rising edge of iTx_done (registered previous value; a held level counts once) advances the FSM.
  - WAIT_TAG goes to SEND_DATA.
  - WAIT_DATA goes to IDLE, oGrant is cleared, and pointer = winner + 1 mod C_NUM_REQ.
- Watchdog:
  - 16-bit counter, cleared on entry to SEND_TAG and SEND_DATA; runs through SEND and WAIT.
  - When it reaches C_TIMEOUT-1: pulse oTimeout, go to IDLE, advance the pointer past the winner, and drop the byte (no retry).
  - If iTx_done rises in the same cycle as expiry, done wins and oTimeout stays 0.
- Throughput:
  - The earliest oTx_Val is 2 cycles after iReq_Val rises (assuming iTx_Rdy = 1): ack/latch edge, then send edge.
  - IDLE is re-entered for 1 cycle between transactions.
- Boundary cases:
  - A requester dropping iReq_Val before it is acknowledged is legal and is simply ignored.
  - If all requesters are valid, each is served once per C_NUM_REQ transactions.
  - When iTx_Rdy stays low, the block waits in SEND (the watchdog is running).
  - iCfg_Check_odd and iCfg_Check_even both set is passed through unchanged; the transmitter defines the result.

Decomposition:
- Package uart_pkg holds:
  - FSM state encoding.
  - C_TAG_BASE.
  - C_DEFAULT_DIV.
  - Watchdog counter width.
- Sub-module uart_rr_arbiter: combinational. Inputs are the request vector and pointer; outputs are a one-hot winner and its index. It is also reused later for RX-side routing.

Test Plan:
- Single request: req1 valid with 8'h55, tag off, iTx_Rdy = 1.
  - oReq_Ack[1] pulses 1 cycle; oTx_Val pulses once with 8'h55.
  - After iTx_done: oBusy = 0, pointer = 2.
- Round-robin: all 4 requesters valid (bytes 10/11/12/13), pointer = 0.
  - Byte order on oTx_Data is 10, 11, 12, 13, with exactly 4 oTx_Val pulses.
- Tag mode: iTag_en = 1, req2 sends 8'h3C.
  - oTx_Data sequence is A2, 3C; the second oTx_Val comes only after the first iTx_done edge.
- Config latch: iCfg_Clk_Div = 27 applied mid-transaction.
  - oTx_Clk_Div stays 434 until the next grant, then becomes 27.
- Timeout: iTx_done never asserted, C_TIMEOUT = 100.
  - oTimeout pulses exactly 100 cycles after SEND entry; FSM returns to IDLE; the next requester is served.
  - Variant: done on the expiry cycle gives no timeout.
- Reset mid-byte: Rst_n low during WAIT_DATA.
  - Outputs go to reset values immediately (oTx_Clk_Div = 434).
  - After release, the same request is re-acknowledged.
